// File: rtl/prime_tester_param_if.sv
// prime_tester_param_if
//   Groups the control and result signals of the primality tester.
//   Parameter WIDTH : operand width in bits (4..24).
//   Signals:
//     enable   - module selected by the top-level menu
//     next     - single-cycle debounced button pulse
//     data_in  - number to test
//     textOut  - 32 ASCII chars, char 0 in [255:248]; chars 0-15 line 1, 16-31 line 2
//     busy     - high while testing
//     done     - high while a result is held
//     is_prime - verdict, valid when done=1
//     factor   - smallest divisor >= 2 if composite, else 0; valid when done=1
//   Modports: master drives the inputs, slave is the tester itself.
interface prime_tester_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             next;
    logic [WIDTH-1:0] data_in;
    logic [255:0]     textOut;
    logic             busy;
    logic             done;
    logic             is_prime;
    logic [WIDTH-1:0] factor;

    modport master (
        output enable, next, data_in,
        input  textOut, busy, done, is_prime, factor
    );

    modport slave (
        input  enable, next, data_in,
        output textOut, busy, done, is_prime, factor
    );
endinterface

// File: rtl/prime_tester_param.sv
// prime_tester_param
//   Multi-cycle trial-division primality tester with 2x16 LCD text output.
//   Each trial runs a restoring divider (one quotient bit per clock); divisors are
//   tried from 2 upward while d*d <= A, and the first exact divisor is reported.
//   Parameter WIDTH : operand width in bits (4..24).
//   Ports:
//     Clk   - system clock, rising edge
//     reset - asynchronous, active-high reset
//     bus   - slave modport of prime_tester_param_if (enable, next, data_in in;
//             textOut, busy, done, is_prime, factor out)
module prime_tester_param #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 Clk,
    input logic                 reset,
    prime_tester_param_if.slave bus
);

    localparam int unsigned NDIG = (WIDTH + 3) / 4;
    // d is one bit wider than A so the d+1 step can never wrap
    localparam int unsigned DW   = WIDTH + 1;
    localparam int unsigned CW   = $clog2(WIDTH);

    localparam logic [255:0] TxtReset = {"Prime Tester    ", "Press Btnc      "};
    localparam logic [255:0] TxtLoad  = {"Input Number    ", "Then Press Btnc "};
    localparam logic [255:0] TxtCalc  = {"Calculating...  ", "                "};

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRange,
        StDivInit,
        StDivide,
        StCheck,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [DW-1:0]    d_q, d_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_prime_q, is_prime_d;
    logic [WIDTH-1:0] factor_q, factor_d;
    logic [255:0]     text_q, text_d;

    logic [DW:0]        rem_sh;
    logic [2*DW-1:0]    d_sq;
    logic [2*DW-1:0]    a_ext;
    logic [4*NDIG-1:0]  fac_pad;
    logic [127:0]       line1, line2;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        d_d        = d_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        is_prime_d = is_prime_q;
        factor_d   = factor_q;

        rem_sh = {rem_q, quo_q[WIDTH-1]};
        // Full-width square: never overflows even at the top of the operand range
        d_sq   = {{DW{1'b0}}, d_q} * {{DW{1'b0}}, d_q};
        a_ext  = {{(2*DW-WIDTH){1'b0}}, a_q};

        unique case (state_q)
            StIdle: begin
                if (bus.enable && bus.next) state_d = StLoad;
            end
            StLoad: begin
                if (bus.next) begin
                    a_d     = bus.data_in;
                    d_d     = DW'(2);
                    state_d = StRange;
                end
            end
            StRange: begin
                if ((a_q < WIDTH'(2)) || (d_sq > a_ext)) begin
                    is_prime_d = (a_q >= WIDTH'(2));
                    factor_d   = '0;
                    state_d    = StDone;
                end else begin
                    state_d = StDivInit;
                end
            end
            StDivInit: begin
                rem_d   = '0;
                quo_d   = a_q;
                cnt_d   = CW'(WIDTH - 1);
                state_d = StDivide;
            end
            StDivide: begin
                if (rem_sh >= {1'b0, d_q}) begin
                    rem_d = DW'(rem_sh - {1'b0, d_q});
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[DW-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = StCheck;
            end
            StCheck: begin
                if (rem_q == '0) begin
                    factor_d   = d_q[WIDTH-1:0];
                    is_prime_d = 1'b0;
                    state_d    = StDone;
                end else begin
                    d_d     = d_q + DW'(1);
                    state_d = StRange;
                end
            end
            StDone: begin
                if (bus.next) begin
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                    state_d    = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase

        // Deselection abandons any work in flight and returns to the reset condition
        if (!bus.enable && (state_q != StIdle)) begin
            state_d    = StIdle;
            a_d        = '0;
            d_d        = DW'(2);
            rem_d      = '0;
            quo_d      = '0;
            cnt_d      = '0;
            is_prime_d = 1'b0;
            factor_d   = '0;
        end

        // Text follows the next state so it changes on the same edge as the state
        fac_pad                = '0;
        fac_pad[WIDTH-1:0]     = factor_d;
        line1                  = is_prime_d ? "PRIME           " : "NOT PRIME       ";
        line2                  = "Factor: 0x      ";
        for (int i = 0; i < int'(NDIG); i++) begin
            line2[127-8*(10+i) -: 8] = hex_char(fac_pad[4*(int'(NDIG)-1-i) +: 4]);
        end

        unique case (state_d)
            StIdle:                               text_d = TxtReset;
            StLoad:                               text_d = TxtLoad;
            StRange, StDivInit, StDivide, StCheck: text_d = TxtCalc;
            StDone:                               text_d = {line1, line2};
            default:                              text_d = TxtReset;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            d_q        <= DW'(2);
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            is_prime_q <= 1'b0;
            factor_q   <= '0;
            text_q     <= TxtReset;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            d_q        <= d_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            is_prime_q <= is_prime_d;
            factor_q   <= factor_d;
            text_q     <= text_d;
        end
    end

    assign bus.busy     = (state_q == StRange) || (state_q == StDivInit) ||
                          (state_q == StDivide) || (state_q == StCheck);
    assign bus.done     = (state_q == StDone);
    assign bus.is_prime = is_prime_q;
    assign bus.factor   = factor_q;
    assign bus.textOut  = text_q;

endmodule

// File: tb/tb_prime_tester_param.sv
// tb_prime_tester_param
//   Drives a WIDTH=8 and a WIDTH=16 tester and compares every result against a
//   plain-arithmetic trial-division model: verdict, smallest factor, busy length
//   and LCD text, including abort by reset and by deselection.
module tb_prime_tester_param;

    localparam int LIMIT = 20000;

    logic Clk = 1'b0;
    logic reset;
    always #5 Clk = ~Clk;

    prime_tester_param_if #(.WIDTH(8))  bus8 ();
    prime_tester_param_if #(.WIDTH(16)) bus16 ();

    prime_tester_param #(.WIDTH(8)) dut8 (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus8)
    );

    prime_tester_param #(.WIDTH(16)) dut16 (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] txt_reset, txt_load;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_factor(input int a);
        if (a < 2) return 0;
        for (int d = 2; d * d <= a; d++) if (a % d == 0) return d;
        return 0;
    endfunction

    function automatic int ref_busy(input int a, input int w);
        int f;
        int t;
        f = ref_factor(a);
        if (f != 0) return (f - 1) * (w + 3);
        t = 0;
        if (a >= 2) for (int d = 2; d * d <= a; d++) t++;
        return t * (w + 3) + 1;
    endfunction

    function automatic logic [255:0] str2bits(input string s);
        logic [255:0] b;
        b = {32{8'h20}};
        for (int i = 0; i < 32 && i < s.len(); i++) b[255-8*i -: 8] = s[i];
        return b;
    endfunction

    function automatic logic [255:0] result_text(input bit p, input int f, input int w);
        string hx;
        string s;
        int nd;
        int nib;
        hx = "0123456789ABCDEF";
        s  = p ? "PRIME           " : "NOT PRIME       ";
        s  = {s, "Factor: 0x"};
        nd = (w + 3) / 4;
        for (int i = 0; i < nd; i++) begin
            nib = (f >> (4 * (nd - 1 - i))) & 15;
            s = {s, hx.substr(nib, nib)};
        end
        return str2bits(s);
    endfunction

    // ---------------- WIDTH=8 helpers ----------------
    task automatic pulse8();
        @(negedge Clk) bus8.next = 1'b1;
        @(negedge Clk) bus8.next = 1'b0;
    endtask

    task automatic enter_load8(input string tag);
        pulse8();
        check_eq({tag, " load text"}, bus8.textOut, txt_load);
        check_eq({tag, " load done"}, bus8.done, 1'b0);
        check_eq({tag, " load prime"}, bus8.is_prime, 1'b0);
        check_eq({tag, " load factor"}, bus8.factor, 0);
    endtask

    task automatic run8(input int a, input bit inject);
        int  cyc;
        int  f;
        bit  p;
        string tag;
        tag = $sformatf("w8 A=%0d", a);
        bus8.data_in = a[7:0];
        pulse8();
        bus8.data_in = 8'($urandom);
        cyc = 0;
        while (bus8.busy && cyc < LIMIT) begin
            bus8.next = inject && (cyc == 3);
            cyc++;
            @(negedge Clk);
        end
        bus8.next = 1'b0;
        f = ref_factor(a);
        p = (a >= 2) && (f == 0);
        check_eq({tag, " busy clks"}, cyc, ref_busy(a, 8));
        check_eq({tag, " done"}, bus8.done, 1'b1);
        check_eq({tag, " is_prime"}, bus8.is_prime, p);
        check_eq({tag, " factor"}, bus8.factor, f);
        check_eq({tag, " text"}, bus8.textOut, result_text(p, f, 8));
    endtask

    task automatic check_cleared8(input string tag);
        check_eq({tag, " busy"}, bus8.busy, 1'b0);
        check_eq({tag, " done"}, bus8.done, 1'b0);
        check_eq({tag, " is_prime"}, bus8.is_prime, 1'b0);
        check_eq({tag, " factor"}, bus8.factor, 0);
        check_eq({tag, " text"}, bus8.textOut, txt_reset);
    endtask

    // ---------------- WIDTH=16 helpers ----------------
    task automatic pulse16();
        @(negedge Clk) bus16.next = 1'b1;
        @(negedge Clk) bus16.next = 1'b0;
    endtask

    task automatic run16(input int a);
        int  cyc;
        int  f;
        bit  p;
        string tag;
        tag = $sformatf("w16 A=%0d", a);
        pulse16();
        check_eq({tag, " load text"}, bus16.textOut, txt_load);
        bus16.data_in = a[15:0];
        pulse16();
        bus16.data_in = 16'($urandom);
        cyc = 0;
        while (bus16.busy && cyc < LIMIT) begin
            cyc++;
            @(negedge Clk);
        end
        f = ref_factor(a);
        p = (a >= 2) && (f == 0);
        check_eq({tag, " busy clks"}, cyc, ref_busy(a, 16));
        check_eq({tag, " done"}, bus16.done, 1'b1);
        check_eq({tag, " is_prime"}, bus16.is_prime, p);
        check_eq({tag, " factor"}, bus16.factor, f);
        check_eq({tag, " text"}, bus16.textOut, result_text(p, f, 16));
    endtask

    initial begin
        int directed [8] = '{97, 91, 49, 0, 1, 2, 255, 251};

        txt_reset = str2bits("Prime Tester    Press Btnc      ");
        txt_load  = str2bits("Input Number    Then Press Btnc ");

        reset         = 1'b1;
        bus8.enable   = 1'b0;
        bus8.next     = 1'b0;
        bus8.data_in  = '0;
        bus16.enable  = 1'b0;
        bus16.next    = 1'b0;
        bus16.data_in = '0;
        repeat (3) @(negedge Clk);
        check_cleared8("reset");
        reset = 1'b0;

        // next without enable must stay in IDLE
        pulse8();
        check_eq("idle no enable text", bus8.textOut, txt_reset);

        bus8.enable = 1'b1;
        enter_load8("first");

        foreach (directed[i]) begin
            run8(directed[i], i < 2);
            enter_load8($sformatf("after %0d", directed[i]));
        end

        // Asynchronous reset in the middle of a divide
        bus8.data_in = 8'd251;
        pulse8();
        repeat (4) @(negedge Clk);
        check_eq("pre-reset busy", bus8.busy, 1'b1);
        reset = 1'b1;
        #1;
        check_cleared8("async reset");
        @(negedge Clk) reset = 1'b0;
        enter_load8("post reset");
        run8(13, 1'b0);
        enter_load8("post 13a");

        // Deselect in the middle of a divide
        bus8.data_in = 8'd251;
        pulse8();
        repeat (4) @(negedge Clk);
        check_eq("pre-deselect busy", bus8.busy, 1'b1);
        bus8.enable = 1'b0;
        @(negedge Clk);
        check_cleared8("deselect");
        bus8.enable = 1'b1;
        enter_load8("post deselect");
        run8(13, 1'b0);
        enter_load8("post 13b");

        // Randomized back-to-back runs, some with stray next pulses while busy
        repeat (25) begin
            run8(int'($urandom_range(0, 255)), 1'($urandom));
            enter_load8("random");
        end

        bus16.enable = 1'b1;
        run16(65521);
        run16(65535);
        run16(int'($urandom_range(0, 65535)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
